// File: rtl/frame_region_pkg.sv
// frame_region_pkg
// Shared types and Ethernet constants for the frame region controller and
// the blocks downstream of it.
//   state_t      : frame lifecycle states (IDLE, HEADER, PAYLOAD, DROP)
//   ETH_*        : standard L2 sizes used as parameter defaults
//   frame_err_t  : per-frame error flags for downstream status buses
package frame_region_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  localparam int ETH_HDR_BYTES  = 14;
  localparam int VLAN_TAG_BYTES = 4;
  localparam int ETH_MIN_FRAME  = 60;
  localparam int ETH_MAX_FRAME  = 1518;

  typedef struct packed {
    logic hdr_trunc;
    logic runt;
    logic oversize;
  } frame_err_t;

endpackage

// File: rtl/frame_region_fsm_counter.sv
// beat_offset_counter
// Holds the frame offset of byte 0 of the current beat and computes the
// running length including the current beat. Both saturate at 2^CNT_W-1.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   accept         : beat transferred this cycle
//   last           : current beat is the final beat of the frame
//   keep_bytes     : valid bytes on the final beat (already normalised)
//   byte_offset    : offset of byte 0 of the current beat
//   run_len        : byte_offset + bytes in the current beat, saturated
module beat_offset_counter #(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             last,
  input  logic [CNT_W-1:0] keep_bytes,
  output logic [CNT_W-1:0] byte_offset,
  output logic [CNT_W-1:0] run_len
);

  localparam logic [CNT_W:0] SAT_VAL = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] beat_len;
  logic [CNT_W:0]   sum;

  assign beat_len = last ? keep_bytes : CNT_W'(DATA_BYTES);
  assign sum      = {1'b0, byte_offset} + {1'b0, beat_len};
  assign run_len  = (sum > SAT_VAL) ? SAT_VAL[CNT_W-1:0] : sum[CNT_W-1:0];

  // A non-last beat advances to the saturated running length, so a
  // saturated offset stays saturated; the last beat rewinds for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_offset <= '0;
    end else if (accept && last) begin
      byte_offset <= '0;
    end else if (accept) begin
      byte_offset <= run_len;
    end
  end

endmodule

// File: rtl/frame_region_fsm.sv
// frame_region_fsm
// Frame lifecycle controller for the AXI-Stream Ethernet parser. Tracks the
// region (header / payload / drop) of each accepted beat, extends the header
// on an 802.1Q tag, reports frame length and classifies runt, truncated
// header and oversize frames.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   beat_accept         : tvalid & tready
//   tlast, tkeep_cnt    : last beat and its valid byte count (0 = full beat)
//   vlan_tag            : TPID 0x8100 seen, sampled on the beat holding byte HDR_BYTES-1
//   frame_start/end     : first / last accepted beat of a frame
//   hdr_done            : accepted beat containing the last header byte
//   in_header/payload/drop : region of the current (pending) beat
//   byte_offset         : offset of byte 0 of the current beat
//   frame_len           : total frame bytes while frame_end is high
//   err_*               : error pulses, qualified with the accepted beat
module frame_region_fsm
  import frame_region_pkg::*;
#(
  parameter int DATA_BYTES      = 8,
  parameter int HDR_BYTES       = ETH_HDR_BYTES,
  parameter int VLAN_EN         = 1,
  parameter int VLAN_BYTES      = VLAN_TAG_BYTES,
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME,
  parameter int CNT_W           = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              beat_accept,
  input  logic                              tlast,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   tkeep_cnt,
  input  logic                              vlan_tag,
  output logic                              frame_start,
  output logic                              frame_end,
  output logic                              hdr_done,
  output logic                              in_header,
  output logic                              in_payload,
  output logic                              in_drop,
  output logic [CNT_W-1:0]                  byte_offset,
  output logic [CNT_W-1:0]                  frame_len,
  output logic                              err_hdr_trunc,
  output logic                              err_runt,
  output logic                              err_oversize
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_HEADER  = ST_HEADER;
  localparam logic [1:0] S_PAYLOAD = ST_PAYLOAD;
  localparam logic [1:0] S_DROP    = ST_DROP;

  logic [1:0]       state, next_state;
  logic             vlan_q, vlan_eff, tag_beat;
  logic             acc, hdr_reached, over;
  logic [CNT_W-1:0] keep_bytes, run_len;
  logic [CNT_W:0]   off_w, end_w, hdr_end, rl_w;
  frame_err_t       err;

  // Qualifying with rst_n keeps every output at zero while reset is held,
  // even if the ingress side is still presenting beats.
  assign acc        = beat_accept & rst_n;
  assign keep_bytes = (tkeep_cnt == '0) ? CNT_W'(DATA_BYTES) : CNT_W'(tkeep_cnt);

  beat_offset_counter #(
    .DATA_BYTES (DATA_BYTES),
    .CNT_W      (CNT_W)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept      (acc),
    .last        (tlast),
    .keep_bytes  (keep_bytes),
    .byte_offset (byte_offset),
    .run_len     (run_len)
  );

  // One extra bit so offset + DATA_BYTES never wraps in the comparisons.
  assign off_w    = {1'b0, byte_offset};
  assign end_w    = off_w + (CNT_W+1)'(DATA_BYTES);
  assign rl_w     = {1'b0, run_len};
  assign tag_beat = (off_w <= (CNT_W+1)'(HDR_BYTES-1)) &&
                    ((CNT_W+1)'(HDR_BYTES-1) < end_w);
  assign vlan_eff = tag_beat ? vlan_tag : vlan_q;
  assign hdr_end  = (CNT_W+1)'(HDR_BYTES) +
                    (((VLAN_EN != 0) && vlan_eff) ? (CNT_W+1)'(VLAN_BYTES) : '0);
  assign hdr_reached = (end_w >= hdr_end);
  assign over        = (rl_w > (CNT_W+1)'(MAX_FRAME_BYTES));

  // The tag decision is held for the rest of the frame and forgotten at its
  // end so the next frame starts untagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vlan_q <= 1'b0;
    end else if (acc && tlast) begin
      vlan_q <= 1'b0;
    end else if (acc && tag_beat) begin
      vlan_q <= vlan_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // tlast wins over every other transition; oversize is only flagged
  // before entering DROP, so it pulses at most once per frame.
  always_comb begin
    next_state    = state;
    frame_start   = 1'b0;
    frame_end     = 1'b0;
    hdr_done      = 1'b0;
    in_header     = 1'b0;
    in_payload    = 1'b0;
    in_drop       = 1'b0;
    err           = '0;
    case (state)
      S_IDLE, S_HEADER: begin
        in_header     = (state == S_HEADER) | acc;
        frame_start   = acc & (state == S_IDLE);
        hdr_done      = acc & hdr_reached;
        frame_end     = acc & tlast;
        err.hdr_trunc = acc & tlast & ~hdr_reached;
        err.oversize  = acc & over;
        if (acc) begin
          if (tlast)            next_state = S_IDLE;
          else if (over)        next_state = S_DROP;
          else if (hdr_reached) next_state = S_PAYLOAD;
          else                  next_state = S_HEADER;
        end
      end
      S_PAYLOAD: begin
        in_payload   = 1'b1;
        frame_end    = acc & tlast;
        err.oversize = acc & over;
        if (acc) begin
          if (tlast)     next_state = S_IDLE;
          else if (over) next_state = S_DROP;
        end
      end
      S_DROP: begin
        in_drop   = 1'b1;
        frame_end = acc & tlast;
        if (acc && tlast) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    err.runt = frame_end & (rl_w < (CNT_W+1)'(MIN_FRAME_BYTES));
  end

  assign frame_len     = frame_end ? run_len : '0;
  assign err_hdr_trunc = err.hdr_trunc;
  assign err_runt      = err.runt;
  assign err_oversize  = err.oversize;

endmodule

// File: doc/frame_region_fsm.md
# frame_region_fsm

Parametrised frame lifecycle controller for the AXI-Stream Ethernet parser; successor to the fixed three-state frame control FSM. It has an internal byte-offset counter, so no external header-done strobe is needed. It derives the header length at runtime, extending it when an 802.1Q tag is seen. It reports frame length and classifies runt, truncated-header and oversize frames, discarding oversize tails through a dedicated DROP region. It sits between the AXI ingress handshake logic and the field extractors and payload path.

## Interface
- DATA_BYTES, 8: bytes per beat, power of two, 1..64
- HDR_BYTES, 14: base L2 header length in bytes, at least 2
- VLAN_EN, 1: enables header extension on a VLAN tag
- VLAN_BYTES, 4: extension length added when tagged
- MIN_FRAME_BYTES, 60: runt threshold; a frame shorter than this is a runt
- MAX_FRAME_BYTES, 1518: oversize threshold; a frame longer than this is oversize
- CNT_W, 16: width of the offset and length counters
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- beat_accept  in  1  tvalid & tready, beat transferred this cycle
- tlast  in  1  last beat of frame, qualified by beat_accept
- tkeep_cnt  in  $clog2(DATA_BYTES+1)  valid bytes on the tlast beat; 0 is treated as DATA_BYTES
- vlan_tag  in  1  TPID 0x8100 detected; qualified on the beat covering byte HDR_BYTES-1
- frame_start  out  1  first accepted beat of a frame
- frame_end  out  1  accepted tlast beat
- hdr_done  out  1  accepted beat that contains the last header byte
- in_header / in_payload / in_drop  out  1 each  region of the current beat; one-hot or all zero
- byte_offset  out  CNT_W  frame offset of byte 0 of the current beat
- frame_len  out  CNT_W  total frame bytes; valid while frame_end is high
- err_hdr_trunc / err_runt / err_oversize  out  1 each  error pulses

## Operation
- States: IDLE, HEADER, PAYLOAD, DROP. No other state is reachable; any illegal encoding goes to IDLE.
- IDLE + beat_accept: frame_start=1, in_header=1, byte_offset=0. Next state is HEADER, unless hdr_done or tlast redirects it.
- vlan_eff = vlan_tag on the beat where byte_offset <= HDR_BYTES-1 < byte_offset+DATA_BYTES. On every other beat, vlan_eff = vlan_q, the value latched from that beat.
- hdr_end = HDR_BYTES + (VLAN_EN & vlan_eff ? VLAN_BYTES : 0).
- hdr_done = beat_accept & (IDLE|HEADER) & (byte_offset + DATA_BYTES >= hdr_end). Next state is PAYLOAD.
- beat_len = tlast ? tkeep_cnt_eff : DATA_BYTES. run_len = byte_offset + beat_len, saturating at 2^CNT_W-1.
- In PAYLOAD, the first accepted beat with run_len > MAX_FRAME_BYTES pulses err_oversize. Next state is DROP. That beat still reports in_payload.
- DROP: in_drop=1 and byte_offset keeps counting. Only tlast leaves DROP. err_oversize pulses once per frame.
- tlast has priority over every other transition:
  - frame_end=1, frame_len=run_len, next state IDLE, byte_offset cleared.
  - err_runt = run_len < MIN_FRAME_BYTES.
  - err_hdr_trunc = tlast in IDLE/HEADER without hdr_done on the same beat.
  - tlast with hdr_done on the same beat is a legal frame with no trunc error.
  - tlast in PAYLOAD on the crossing beat raises err_oversize with frame_end. This is checked for HEADER beats too.
- A cycle without beat_accept holds all registers. Every pulse output is 0 in such a cycle; region flags keep reporting the pending beat.

## Timing
- Registered: state, byte_offset, vlan_q.
- All pulses, region flags and frame_len are combinational from the registers and the same-cycle inputs, with zero latency.
- Single-beat frame: frame_start, hdr_done (if covered), frame_end and errors all assert in the same cycle.
- Reset values:
  - state=IDLE, byte_offset=0, vlan_q=0.
  - All outputs 0 while rst_n is low.
- Reset asserted mid-frame aborts the frame: no frame_end and no errors are emitted for it. The next accepted beat produces frame_start.
- byte_offset increments by DATA_BYTES per accepted non-last beat and saturates. Once saturated it stays saturated; it does not wrap.

## Structure
- frame_region_pkg:
  - state_t enum.
  - ETH_HDR_BYTES=14, VLAN_TAG_BYTES=4, ETH_MIN_FRAME=60, ETH_MAX_FRAME=1518.
  - frame_err_t struct {hdr_trunc, runt, oversize} for downstream status buses.
- Sub-module beat_offset_counter: saturating byte_offset register plus run_len adder, parametrised by DATA_BYTES and CNT_W.
- The FSM and classification logic stay in the top module.

## Test plan
All scenarios use DATA_BYTES=8 unless stated.
- Untagged 64-byte frame, 8 beats, tkeep_cnt=8 on beat 7 -> frame_start on beat 0; in_header on beats 0-1; hdr_done on beat 1; in_payload on beats 2-7; frame_end on beat 7 with frame_len=64; no errors.
- Tagged frame, vlan_tag=1 on beat 1 -> hdr_end=18; hdr_done on beat 2; in_payload from beat 3; the next untagged frame uses hdr_end=14.
- 5 beats, tkeep_cnt=4 on the last beat -> frame_len=36 with err_runt and frame_end; err_hdr_trunc=0.
- Single beat, tlast, tkeep_cnt=6 -> in the same cycle: frame_start, frame_end, err_hdr_trunc, err_runt, frame_len=6; hdr_done=0.
- 200 full beats -> err_oversize on beat 189 (offset 1512, run_len 1520); in_drop on beats 190-199; frame_end on beat 199 with frame_len=1600.
- Random beat_accept gaps, plus rst_n pulsed at beat 4 of a payload frame -> outputs identical to the gap-free run except for timing; after reset, state is IDLE and byte_offset=0, and no frame_end is emitted for the aborted frame.
